// File: rtl/bcrypt_pkg.sv
// Shared bcrypt definitions: ciphertext geometry, transmit state encoding and the
// "OrpheanBeholderScryDoubt" initial constants also used by the core.
package bcrypt_pkg;

  localparam int unsigned CT_WORDS = 6;
  localparam int unsigned CT_BYTES = 24;
  localparam int unsigned CT_BITS  = CT_WORDS * 32;

  localparam logic [CT_BITS-1:0] BCRYPT_CTEXT_INIT = {
    32'h4f727068, 32'h65616e42, 32'h65686f6c,
    32'h64657253, 32'h63727944, 32'h6f756274
  };

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StStart,
    StData,
    StStop,
    StFinish
  } tx_state_t;

  // Byte idx of the packed ciphertext, byte 0 being the MSB of word 0.
  function automatic logic [7:0] ct_byte(logic [CT_BITS-1:0] ct, logic [4:0] idx);
    logic [CT_BITS-1:0] shifted;
    shifted = ct << {idx, 3'b000};
    return shifted[CT_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/bcrypt_ctext_tx_if.sv
// Capture/data/flow-control bundle between the bcrypt datapath, the host link and
// the ciphertext transmitter.
interface bcrypt_ctext_tx_if;
  logic        capture;
  logic [31:0] ct_Orph;
  logic [31:0] ct_eanB;
  logic [31:0] ct_ehol;
  logic [31:0] ct_derS;
  logic [31:0] ct_cryD;
  logic [31:0] ct_oubt;
  logic        cts;
  logic        tx;
  logic        busy;
  logic        done;
  logic        capture_drop;

  modport master (
    output capture, ct_Orph, ct_eanB, ct_ehol, ct_derS, ct_cryD, ct_oubt, cts,
    input  tx, busy, done, capture_drop
  );

  modport slave (
    input  capture, ct_Orph, ct_eanB, ct_ehol, ct_derS, ct_cryD, ct_oubt, cts,
    output tx, busy, done, capture_drop
  );
endinterface

// File: rtl/bcrypt_ctext_tx_uart_tx_8n1.sv
// Byte-level 8N1 UART transmitter, LSB first. ready_o is also raised in the final
// stop-bit cycle so a following byte starts with no idle gap.
module uart_tx_8n1
  import bcrypt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam logic [CNT_W-1:0] BitLast = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == BitLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_o = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d   = '0;
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = StStart;
          shift_d = data_i;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          ready_o = 1'b1;
          if (valid_i) begin
            state_d = StStart;
            shift_d = data_i;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Line level follows the next state so tx is a clean flop output.
    tx_d = 1'b1;
    if (state_d == StStart)     tx_d = 1'b0;
    else if (state_d == StData) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/bcrypt_ctext_tx.sv
// Latches the six bcrypt ciphertext words on capture and streams them to the host
// as 24 UART bytes, MSB byte of each word first, gated by host cts at byte boundaries.
module bcrypt_ctext_tx
  import bcrypt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  bcrypt_ctext_tx_if.slave  bus
);

  // Sequencer uses StData for "a byte is on the line".
  tx_state_t          seq_q, seq_d;
  logic [4:0]         idx_q, idx_d;
  logic [CT_BITS-1:0] shadow_q, shadow_d;
  logic               drop_q, drop_d;

  logic [CT_BITS-1:0] ct_in, src;
  logic [4:0]         send_idx;
  logic               uart_valid, uart_ready, uart_tx;
  logic [7:0]         uart_data;

  assign ct_in = {bus.ct_Orph, bus.ct_eanB, bus.ct_ehol, bus.ct_derS, bus.ct_cryD, bus.ct_oubt};

  always_comb begin
    seq_d      = seq_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    uart_valid = 1'b0;
    send_idx   = idx_q;
    src        = shadow_q;
    drop_d     = bus.capture && (seq_q != StIdle);
    case (seq_q)
      StIdle: begin
        if (bus.capture) begin
          shadow_d = ct_in;
          idx_d    = '0;
          send_idx = '0;
          // Byte 0 goes straight from the inputs so tx drops the cycle after capture.
          src      = ct_in;
          if (bus.cts) begin
            uart_valid = 1'b1;
            seq_d      = StData;
          end else begin
            seq_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus.cts) begin
          uart_valid = 1'b1;
          seq_d      = StData;
        end
      end
      StData: begin
        if (uart_ready) begin
          if (idx_q == 5'(CT_BYTES - 1)) begin
            seq_d = StFinish;
          end else begin
            idx_d    = idx_q + 5'd1;
            send_idx = idx_q + 5'd1;
            if (bus.cts) uart_valid = 1'b1;
            else         seq_d      = StWait;
          end
        end
      end
      StFinish: seq_d = StIdle;
      default:  seq_d = StIdle;
    endcase
    uart_data = ct_byte(src, send_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q    <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .valid_i (uart_valid),
    .data_i  (uart_data),
    .ready_o (uart_ready),
    .tx_o    (uart_tx)
  );

  assign bus.tx           = uart_tx;
  assign bus.busy         = (seq_q == StWait) || (seq_q == StData);
  assign bus.done         = (seq_q == StFinish);
  assign bus.capture_drop = drop_q;

endmodule

// File: tb/tb_bcrypt_ctext_tx.sv
// Randomized scoreboard bench for bcrypt_ctext_tx: stimulus queues expected bytes,
// done and capture_drop cycles; independent monitors decode tx and compare.
module tb_bcrypt_ctext_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  typedef logic [31:0] words_t [6];
  typedef logic [7:0]  bytes_t [24];
  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  frame_t exp_q[$];
  int     done_q[$];
  int     drop_q[$];

  bcrypt_ctext_tx_if bus ();

  bcrypt_ctext_tx #(
    .CLKS_PER_BIT (C),
    .CNT_W        (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: words go out in order, most significant byte first.
  function automatic bytes_t words_to_bytes(words_t w);
    bytes_t b;
    for (int i = 0; i < 24; i++) b[i] = 8'((w[i / 4] >> (8 * (3 - (i % 4)))) & 32'hff);
    return b;
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    return w;
  endfunction

  // Frame i starts 10*C cycles after frame i-1; frames after stall_after slip by stall.
  task automatic expect_stream(input bytes_t b, input int first, input int stall_after,
                               input int stall);
    for (int i = 0; i < 24; i++) begin
      frame_t f;
      f.data  = b[i];
      f.start = first + FRAME * i + ((i > stall_after) ? stall : 0);
      exp_q.push_back(f);
    end
    done_q.push_back(first + 24 * FRAME + stall);
  endtask

  task automatic drive_words(input words_t w);
    bus.ct_Orph = w[0];
    bus.ct_eanB = w[1];
    bus.ct_ehol = w[2];
    bus.ct_derS = w[3];
    bus.ct_cryD = w[4];
    bus.ct_oubt = w[5];
  endtask

  task automatic capture_once(input words_t w, output int e);
    drive_words(w);
    bus.capture = 1'b1;
    tick();
    e = cyc;
    bus.capture = 1'b0;
    drive_words(rand_words());
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < budget) ? 1 : 0, 1);
  endtask

  // UART receiver: samples every cycle of a frame, so bit width and stability are checked.
  initial begin : uart_mon
    logic [9:0] bits;
    bit         stable;
    bit         aborted;
    int         s;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.tx === 1'b0) begin
        s       = cyc;
        stable  = 1'b1;
        aborted = 1'b0;
        bits    = '0;
        for (int n = 0; n < FRAME; n++) begin
          if (n != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (n % C == 0) bits[n / C] = bus.tx;
          else if (bus.tx !== bits[n / C]) stable = 1'b0;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", longint'(bits[8:1]), -1);
          end else begin
            frame_t f;
            f = exp_q.pop_front();
            chk("byte_data", bits[8:1], f.data);
            chk("byte_start_cycle", s, f.start);
            chk("frame_shape", {stable, bits[0], bits[9]}, 3'b101);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", cyc, -1);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
        chk("busy_low_at_done", bus.busy, 0);
      end
    end
    if (reset === 1'b0 && bus.capture_drop === 1'b1) begin
      if (drop_q.size() == 0) chk("unexpected_capture_drop", cyc, -1);
      else                    chk("capture_drop_cycle", cyc, drop_q.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    words_t magic;
    words_t zeros;
    words_t ones;
    words_t w;
    bytes_t magic_b;
    string  ref_str;
    int     e, d, t, stall, wcyc, f;
    int     bad_tx, bad_busy, bad_done, bad_drop;

    magic   = '{32'h4f727068, 32'h65616e42, 32'h65686f6c,
                32'h64657253, 32'h63727944, 32'h6f756274};
    zeros   = '{default: 32'h0};
    ones    = '{default: 32'hffffffff};
    ref_str = "OrpheanBeholderScryDoubt";
    for (int i = 0; i < 24; i++) magic_b[i] = ref_str[i];

    bus.capture = 1'b0;
    bus.cts     = 1'b1;
    drive_words(zeros);
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_drop = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1)           bad_tx++;
      if (bus.busy !== 1'b0)         bad_busy++;
      if (bus.done !== 1'b0)         bad_done++;
      if (bus.capture_drop !== 1'b0) bad_drop++;
    end
    chk("idle_tx_not_high", bad_tx, 0);
    chk("idle_busy_high", bad_busy, 0);
    chk("idle_done_high", bad_done, 0);
    chk("idle_drop_high", bad_drop, 0);
    tick();

    // Magic constants decode to the ASCII string, back to back
    capture_once(magic, e);
    expect_stream(magic_b, e, 99, 0);
    @(negedge clk);
    chk("busy_after_capture", bus.busy, 1);
    chk("tx_low_after_capture", bus.tx, 0);
    wait_drain(30 * FRAME);
    chk("busy_after_done", bus.busy, 0);

    // Capture while busy is dropped and leaves the shadow alone
    capture_once(magic, e);
    expect_stream(magic_b, e, 99, 0);
    while (cyc < e + 189) tick();
    drive_words(ones);
    bus.capture = 1'b1;
    drop_q.push_back(cyc + 1);
    tick();
    bus.capture = 1'b0;
    wait_drain(30 * FRAME);

    // cts dropped for 37 cycles during byte 5
    for (int r = 0; r < 2; r++) begin
      w = rand_words();
      capture_once(w, e);
      d     = e + 5 * FRAME + int'($urandom_range(4, FRAME - 1));
      t     = e + 6 * FRAME;
      stall = (d + 38 > t) ? d + 38 - t : 0;
      expect_stream(words_to_bytes(w), e, 5, stall);
      while (cyc < d) tick();
      bus.cts = 1'b0;
      while (cyc < d + 37) tick();
      bus.cts = 1'b1;
      wait_drain(30 * FRAME);
    end

    // Capture with cts low waits in place with tx high
    w = rand_words();
    bus.cts = 1'b0;
    capture_once(w, e);
    wcyc = int'($urandom_range(1, 20));
    expect_stream(words_to_bytes(w), e + wcyc + 1, 99, 0);
    @(negedge clk);
    chk("busy_while_waiting", bus.busy, 1);
    chk("tx_high_while_waiting", bus.tx, 1);
    while (cyc < e + wcyc) tick();
    bus.cts = 1'b1;
    wait_drain(30 * FRAME);

    // Capture in the done cycle is dropped; the next cycle's capture is accepted
    w = rand_words();
    capture_once(w, e);
    expect_stream(words_to_bytes(w), e, 99, 0);
    f = e + 24 * FRAME;
    while (cyc < f) tick();
    drive_words(rand_words());
    bus.capture = 1'b1;
    drop_q.push_back(f + 1);
    tick();
    w = rand_words();
    drive_words(w);
    tick();
    e = cyc;
    bus.capture = 1'b0;
    expect_stream(words_to_bytes(w), e, 99, 0);
    wait_drain(30 * FRAME);

    // Reset mid-frame aborts at once, then an all-zero stream
    capture_once(magic, e);
    expect_stream(magic_b, e, 99, 0);
    while (cyc < e + 190 + int'($urandom_range(0, 20))) tick();
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("tx_high_on_reset", bus.tx, 1);
    chk("busy_low_on_reset", bus.busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();
    capture_once(zeros, e);
    expect_stream(words_to_bytes(zeros), e, 99, 0);
    wait_drain(30 * FRAME);

    repeat (5) tick();
    chk("leftover_frames", exp_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    chk("leftover_drop", drop_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcrypt_ctext_tx.md
Name: bcrypt_ctext_tx

Overview:
- Returns the bcrypt result to the host over the serial link. It is the transmit end of the UART interface whose receive side feeds salt, key and cost into the core.
- Captures the six 32-bit ciphertext words (ct_Orph..ct_oubt) on a capture pulse and serializes them as 24 bytes, 8N1, LSB-first within each byte.
- Sits between the bcrypt datapath outputs and the tx pin.
- Supports host flow control (cts), reports busy, and pulses done.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (minimum 2).
- CNT_W, 16, width of the bit-period counter (must satisfy 2^CNT_W > CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- capture  input  1  single-cycle request to latch the ct_* words and begin transmission.
- ct_Orph  input  32  ciphertext word 0, sent first.
- ct_eanB  input  32  ciphertext word 1.
- ct_ehol  input  32  ciphertext word 2.
- ct_derS  input  32  ciphertext word 3.
- ct_cryD  input  32  ciphertext word 4.
- ct_oubt  input  32  ciphertext word 5, sent last.
- cts  input  1  host clear-to-send; sampled only at byte boundaries.
- tx  output  1  serial data out; idle-high.
- busy  output  1  high from the cycle after an accepted capture until done.
- done  output  1  one-cycle pulse after the final stop bit.
- capture_drop  output  1  one-cycle pulse when capture arrives while busy.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: tx=1, busy=0, done=0, capture_drop=0, state=IDLE, byte index=0, bit counter=0.
- Reset asserted mid-frame aborts immediately: tx returns high asynchronously and no done pulse follows.
- Capture:
  - In IDLE, a capture at edge k latches all six words into a 192-bit shadow register.
  - busy=1 from cycle k+1.
  - ct_* inputs are don't-care after edge k.
- Byte order: word order Orph, eanB, ehol, derS, cryD, oubt; within each word, bits [31:24] first, then [23:16], [15:8], [7:0].
- Frame: start bit 0, data bits d0..d7, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- State machine:
  - IDLE -> START on capture (and only if cts=1, otherwise -> WAIT).
  - WAIT -> START when cts=1. tx is held at 1 in WAIT.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bit periods.
  - STOP -> WAIT/START (next byte) if byte index < 23, else -> FINISH.
  - FINISH lasts 1 cycle: done=1, busy=0, then -> IDLE.
- Timing with cts held at 1:
  - tx low from cycle k+1.
  - Bytes are back-to-back with no idle gap.
  - done asserts in cycle k+1+240*CLKS_PER_BIT.
- cts deassertion:
  - cts low mid-byte does not truncate the byte.
  - cts is checked only when leaving STOP and at capture; each stalled cycle adds one cycle to total latency.
- capture while busy (including in the FINISH cycle): ignored, capture_drop pulses, shadow register unchanged.
- capture in the cycle after FINISH (IDLE again) is accepted normally.
- Arithmetic:
  - Byte index is 5-bit, 0..23, no wrap; reset to 0 on accept.
  - Bit index is 3-bit.
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and clears on every bit transition.

Decomposition:
- bcrypt_pkg (shared package) holds:
  - CT_WORDS=6, CT_BYTES=24.
  - tx_state_t enum {IDLE, WAIT, START, DATA, STOP, FINISH}.
  - The six "OrpheanBeholderScryDoubt" initial constants (0x4f727068, 0x65616e42, 0x65686f6c, 0x64657253, 0x63727944, 0x6f756274), shared with the core.
- One natural sub-module, uart_tx_8n1:
  - Byte-level transmitter with a valid/ready handshake and a CLKS_PER_BIT parameter.
  - The top level owns capture, shadow register, byte sequencing, cts gating and done.

Test Plan:
- Reset idle: assert reset for 3 cycles, release -> tx=1, busy=0, done=0, and all hold for 100 cycles with no capture.
- Single byte check: CLKS_PER_BIT=4, cts=1, ct_* = the six magic constants, capture at cycle 10.
  - tx from cycle 11, each value held 4 cycles: 0,1,1,1,1,0,0,1,0,1 (0x4F 'O').
  - Then 0x72 'r' follows immediately.
- Full stream: same stimulus -> the UART monitor decodes the ASCII string "OrpheanBeholderScryDoubt".
  - done is high only in cycle 971; busy is low from cycle 971.
- Flow control: deassert cts during byte 5, reassert after 37 cycles.
  - Byte 5 completes intact and tx stays 1 during the stall.
  - done is delayed by exactly the stalled cycle count; decoded data is unchanged.
- Capture during busy: second capture at cycle 200 with ct_* = 0xFFFFFFFF -> capture_drop pulses at cycle 201 and the stream still decodes the original string.
- Reset mid-frame: assert reset at cycle 300.
  - tx=1 and busy=0 immediately; no done pulse.
  - After release, a new capture of all-zero words transmits 24 bytes of 0x00.
